// File: rtl/io_port_bank.sv
// Memory-mapped I/O port bank: registered output ports with read-back and
// 2-flop synchronised input ports with sticky change flags and an irq.
module io_port_bank #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int N_PORTS   = 8,
  parameter int OUT_BASE  = 'hE0,
  parameter int STAT_BASE = 'hE8,
  parameter int IN_BASE   = 'hF0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           address,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        write,
  output logic [DATA_W-1:0]           data_out,
  output logic                        hit,
  input  logic [N_PORTS*DATA_W-1:0]   port_in,
  output logic [N_PORTS*DATA_W-1:0]   port_out,
  output logic                        irq
);

  localparam longint SPACE = longint'(1) << ADDR_W;

  function automatic bit overlap(input longint a, input longint b);
    return (a < b + N_PORTS) && (b < a + N_PORTS);
  endfunction

  if (N_PORTS < 1 || N_PORTS > 16 || DATA_W < 2 ||
      OUT_BASE < 0 || STAT_BASE < 0 || IN_BASE < 0 ||
      OUT_BASE + N_PORTS > SPACE || STAT_BASE + N_PORTS > SPACE ||
      IN_BASE + N_PORTS > SPACE ||
      overlap(OUT_BASE, STAT_BASE) || overlap(OUT_BASE, IN_BASE) ||
      overlap(STAT_BASE, IN_BASE)) begin : g_bad_cfg
    $error("io_port_bank: invalid port map or parameter range");
  end

  logic [N_PORTS-1:0][DATA_W-1:0] pin, out_q, sync2_q;
  logic [N_PORTS-1:0]             flag_q, en_q;
  logic                           irq_q;

  assign pin      = port_in;
  assign port_out = out_q;
  assign irq      = irq_q;

  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    logic [DATA_W-1:0] o_q, s1_q, s2_q;
    logic              f_q, f_d, e_q;
    logic              out_wr, stat_wr, chg;

    assign out_wr  = write && (address == ADDR_W'(OUT_BASE + i));
    assign stat_wr = write && (address == ADDR_W'(STAT_BASE + i));
    assign chg     = (s1_q != s2_q);
    // A change on the same edge as a W1C keeps the flag set.
    assign f_d     = chg ? 1'b1 : ((stat_wr && data_in[0]) ? 1'b0 : f_q);

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        o_q  <= '0;
        s1_q <= '0;
        s2_q <= '0;
        f_q  <= 1'b0;
        e_q  <= 1'b0;
      end else begin
        if (out_wr)  o_q <= data_in;
        if (stat_wr) e_q <= data_in[1];
        s1_q <= pin[i];
        s2_q <= s1_q;
        f_q  <= f_d;
      end
    end

    assign out_q[i]   = o_q;
    assign sync2_q[i] = s2_q;
    assign flag_q[i]  = f_q;
    assign en_q[i]    = e_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) irq_q <= 1'b0;
    else        irq_q <= |(flag_q & en_q);
  end

  always_comb begin
    data_out = '0;
    hit      = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (address == ADDR_W'(OUT_BASE + i)) begin
        hit      = 1'b1;
        data_out = out_q[i];
      end
      if (address == ADDR_W'(STAT_BASE + i)) begin
        hit      = 1'b1;
        data_out = DATA_W'({en_q[i], flag_q[i]});
      end
      if (address == ADDR_W'(IN_BASE + i)) begin
        hit      = 1'b1;
        data_out = sync2_q[i];
      end
    end
  end

endmodule

// File: doc/io_port_bank.md
Name: io_port_bank

Overview:
- Parametrised memory-mapped I/O port bank. Successor to the fixed 16-in/16-out port logic inside the memory block.
- Provides a configurable number of registered output ports with read-back, and 2-flop synchronised input ports.
- Each input port has a sticky change flag, a per-port interrupt enable, and a registered interrupt request.
- Sits beside ROM/RAM on the CPU address/data bus; the parent's read mux selects `data_out` when `hit`=1.

Parameters:
- DATA_W, 8, width of bus data and of each port.
- ADDR_W, 8, width of the bus address.
- N_PORTS, 8, number of input ports and of output ports (1..16).
- OUT_BASE, 8'hE0, address of port_out[0]; port_out[i] at OUT_BASE+i, read/write.
- STAT_BASE, 8'hE8, address of status[0]; status[i] at STAT_BASE+i, read/write.
- IN_BASE, 8'hF0, address of port_in[0]; port_in[i] at IN_BASE+i, read-only.
- The three regions must not overlap or exceed 2^ADDR_W. A violation is an elaboration error.

Ports:
- clock  in  1  system clock, all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  bus address from the CPU MAR.
- data_in  in  DATA_W  write data from the CPU.
- write  in  1  write strobe, sampled at the rising clock edge.
- data_out  out  DATA_W  combinational read data for the current address.
- hit  out  1  combinational; 1 when address falls in any of the three regions.
- port_in  in  N_PORTS*DATA_W  asynchronous external inputs; port i occupies bits [i*DATA_W +: DATA_W].
- port_out  out  N_PORTS*DATA_W  registered external outputs, same packing as port_in.
- irq  out  1  registered interrupt request.

Behaviour:
- Reset (reset=0, asynchronous): all port_out=0, sync1/sync2=0, all flags=0, all enables=0, irq=0.
- Output write: write=1 and address=OUT_BASE+i -> port_out[i] <= data_in at that edge. Other ports are unchanged.
- Input synchronisers: each edge, sync1[i] <= port_in[i] and sync2[i] <= sync1[i].
- Change detection: chg[i] = (sync1[i] != sync2[i]), evaluated at the edge.
  - When chg[i]=1, flag[i] is set on the same edge that sync2[i] takes the new value.
  - Latency from a port_in change to visible state: 2 edges to read value and flag, 3 edges to irq.
- Status register layout: bit0 = flag (read; write 1 to clear), bit1 = enable (read/write). Other bits read 0 and ignore writes.
- Status write to STAT_BASE+i: enable[i] <= data_in[1]; if data_in[0]=1, flag[i] is cleared.
- Set/clear collision: a W1C clear and chg[i]=1 on the same edge -> flag stays 1 (set wins).
- irq <= OR over i of (flag[i] & enable[i]), registered, updated every edge.
  - irq drops one edge after the last qualifying flag is cleared or disabled.
- Read mux (combinational), address inside a region:
  - OUT region -> port_out[i].
  - STAT region -> {0.., enable[i], flag[i]}.
  - IN region -> sync2[i].
  - hit=1 in all three cases.
- Read mux, any other address: data_out=0, hit=0.
- Writes to the IN region or to unmapped addresses are ignored with no side effect.
- Reads have no side effects; flags are cleared only by W1C.
- Nonzero port_in at reset release sets the corresponding flags after 2 edges. Enables reset to 0, so no irq results until software enables the port.
- Reset asserted mid-operation clears all state immediately, independent of clock; a write on the same edge as reset is lost.
- Implementation structure: per-port generate loop for the registers plus a single read-mux always block. No internal FSM beyond the per-port flag set/clear logic.

Test Plan:
- Reset then read -> address E0..E7, E8..EF, F0..F7 all read 8'h00 with hit=1; address 8'h80 gives hit=0, data_out=0; irq=0.
- Write address E3 data 8'hA5 -> port_out[3]=A5 after the edge, other ports remain 0; reading E3 returns A5; writing F3 leaves all state unchanged.
- port_in[2] 00->3C between edges -> F2 reads 3C and E8+2 (EA) reads 8'h01 after 2 edges; irq stays 0.
- Write EA=8'h02 with flag[2] set -> irq=1 on the next edge; then write EA=8'h03 -> flag cleared, irq=0 one edge later; EA reads 8'h02.
- Apply a W1C to EA on the same edge that port_in[2] changes again (chg=1) -> flag remains 1 and irq stays asserted.
- Assert reset mid-run with port_out and flags nonzero -> all outputs 0 immediately (asynchronous); after release, held port_in[5]=8'h11 gives ED=8'h01 after 2 edges with irq=0.
